// File: rtl/jtkunio_paldma_if.sv
// Bus bundle for jtkunio_paldma: CPU request, ROM fetch port, palette RAM write port and status.
// The master modport is the DMA engine; the slave modport is the system side (CPU, ROM, RAM).
interface jtkunio_paldma_if #(
  parameter int AW = 9
);
  logic              LVBL;
  logic              dma_cs;
  logic [7:0]        cpu_dout;
  logic [8+AW-1:0]   rom_addr;
  logic              rom_cs;
  logic              rom_ok;
  logic [7:0]        rom_data;
  logic              pal_we;
  logic [AW-1:0]     pal_addr;
  logic [7:0]        pal_din;
  logic              busy;
  logic              dma_irq;

  modport master (
    input  LVBL, dma_cs, cpu_dout, rom_ok, rom_data,
    output rom_addr, rom_cs, pal_we, pal_addr, pal_din, busy, dma_irq
  );

  modport slave (
    output LVBL, dma_cs, cpu_dout, rom_ok, rom_data,
    input  rom_addr, rom_cs, pal_we, pal_addr, pal_din, busy, dma_irq
  );
endinterface

// File: rtl/jtkunio_paldma.sv
// Palette DMA: copies 2^AW bytes from ROM page {page, idx} into palette RAM, one byte at a time.
// Optional macro JTKUNIO_PALDMA_VBLANK_EN restricts fetches to vertical blank (LVBL low).
module jtkunio_paldma #(
  parameter int AW = 9
) (
  input  logic                 rst,
  input  logic                 clk,
  jtkunio_paldma_if.master     bus
);

  typedef enum logic [2:0] {IDLE, WAIT, FETCH, WRITE, DONE} state_t;

  state_t          st, st_nxt;
  logic [7:0]      page;
  logic [AW-1:0]   idx;
  logic [7:0]      pal_din;
  logic            fetch_arm;   // high from the second FETCH cycle on
  logic            last;
  logic            wait_go;
  logic            byte_ok;

  assign last    = &idx;
  assign byte_ok = fetch_arm & bus.rom_ok;

`ifdef JTKUNIO_PALDMA_VBLANK_EN
  assign wait_go = ~bus.LVBL;
`else
  assign wait_go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.dma_cs) st_nxt = WAIT;
      WAIT:    if (wait_go)    st_nxt = FETCH;
      FETCH:   if (byte_ok)    st_nxt = WRITE;
      WRITE:   st_nxt = last ? DONE : WAIT;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // A stale rom_ok left over from the previous byte is masked by fetch_arm
  always_ff @(posedge clk) begin
    if (rst) begin
      page      <= 8'd0;
      idx       <= '0;
      pal_din   <= 8'd0;
      fetch_arm <= 1'b0;
    end else begin
      fetch_arm <= (st == FETCH);
      case (st)
        IDLE: if (bus.dma_cs) begin
          page <= bus.cpu_dout;
          idx  <= '0;
        end
        FETCH: if (byte_ok) pal_din <= bus.rom_data;
        WRITE: if (!last)   idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = {page, idx};
  assign bus.rom_cs   = (st == FETCH);
  assign bus.pal_we   = (st == WRITE);
  assign bus.pal_addr = idx;
  assign bus.pal_din  = pal_din;
  assign bus.busy     = (st == WAIT) || (st == FETCH) || (st == WRITE);
  assign bus.dma_irq  = (st == DONE);

endmodule

// File: tb/tb_jtkunio_paldma.sv
// Scoreboard bench for jtkunio_paldma: expected palette writes are queued at request time
// and popped on every pal_we; a ROM model supplies data with configurable rom_ok latency.
module tb_jtkunio_paldma;
  localparam int AW    = 9;
  localparam int NB    = 1 << AW;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtkunio_paldma_if #(.AW(AW)) bus();

  jtkunio_paldma #(.AW(AW)) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         we_cnt  = 0;
  int         irq_cnt = 0;
  int         cs_cnt  = 0;
  logic [7:0] exp_page = 8'd0;
  int         rom_lat = 1;
  bit         rom_always = 1'b0;
  int         rom_cnt = 0;

`ifdef JTKUNIO_PALDMA_VBLANK_EN
  localparam logic LV_RUN = 1'b0;
`else
  localparam logic LV_RUN = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [8+AW-1:0] a);
    logic [15:0] t;
    t = 16'(a[8+AW-1:8]) * 16'd37;
    return a[7:0] ^ t[7:0];
  endfunction

  // ROM model: rom_ok rises once rom_cs has been seen for rom_lat cycles
  always @(negedge clk) begin
    if (rom_always) begin
      bus.rom_ok = 1'b1;
    end else if (bus.rom_cs) begin
      rom_cnt++;
      bus.rom_ok = (rom_cnt >= rom_lat);
    end else begin
      rom_cnt = 0;
      bus.rom_ok = 1'b0;
    end
    bus.rom_data = rom_fn(bus.rom_addr);
  end

  // Output monitor and scoreboard consumer
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.pal_we) begin
        chk("we_excl_cs", 32'(bus.rom_cs), 32'd0);
        if (sb.size() == 0) begin
          chk("wr_extra", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pal_addr", 32'(bus.pal_addr), 32'(e.a));
          chk("pal_din", 32'(bus.pal_din), 32'(e.d));
        end
        we_cnt++;
      end
      if (bus.rom_cs) begin
        cs_cnt++;
        chk("cs_page", 32'(bus.rom_addr[8+AW-1:AW]), 32'(exp_page));
        chk("cs_idx", 32'(bus.rom_addr[AW-1:0]), 32'(we_cnt));
      end
      if (bus.dma_irq) begin
        irq_cnt++;
        chk("irq_busy", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic start_req(input logic [7:0] pg);
    wr_t w;
    sb.delete();
    for (int i = 0; i < NB; i++) begin
      w.a = AW'(i);
      w.d = rom_fn({pg, AW'(i)});
      sb.push_back(w);
    end
    exp_page = pg;
    we_cnt   = 0;
    irq_cnt  = 0;
    cs_cnt   = 0;
    @(negedge clk);
    bus.dma_cs   = 1'b1;
    bus.cpu_dout = pg;
    @(negedge clk);
    bus.dma_cs   = 1'b0;
    bus.cpu_dout = 8'hA5;
    chk("busy_req", 32'(bus.busy), 32'd1);
  endtask

  // Runs from the first WAIT cycle until dma_irq; optionally injects a second request
  task automatic run_to_irq(input int exp_n, input int inj_at);
    int n;
    n = 0;
    while (!bus.dma_irq && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (n == inj_at) begin
        bus.dma_cs   = 1'b1;
        bus.cpu_dout = 8'h07;
      end else if (n == inj_at + 1) begin
        bus.dma_cs   = 1'b0;
      end
    end
    bus.dma_cs = 1'b0;
    chk("irq_seen", 32'(bus.dma_irq), 32'd1);
    if (exp_n >= 0) chk("xfer_cycles", 32'(n), 32'(exp_n));
    repeat (4) @(negedge clk);
    chk("irq_count", 32'(irq_cnt), 32'd1);
    chk("we_count", 32'(we_cnt), 32'(NB));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    int c;
    bus.LVBL     = LV_RUN;
    bus.dma_cs   = 1'b0;
    bus.cpu_dout = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("rst_pal_we", 32'(bus.pal_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_irq", 32'(bus.dma_irq), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_pal_din", 32'(bus.pal_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // rom_ok two cycles after rom_cs: WAIT + 3 FETCH + WRITE per byte
    rom_always = 1'b0; rom_lat = 3;
    start_req(8'h05);
    run_to_irq(NB * 5, -1);

    // rom_ok stuck high: first FETCH cycle must still be skipped
    rom_always = 1'b1;
    start_req(8'h3C);
    run_to_irq(NB * 4, -1);

    // second request mid-transfer with a different page is ignored
    rom_always = 1'b0; rom_lat = 1;
    start_req(8'h05);
    run_to_irq(NB * 4, 300);

    // reset during FETCH of byte 37 aborts the transfer
    rom_lat = 2;
    start_req(8'h91);
    k = 0;
    while (!(we_cnt == 37 && bus.rom_cs) && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("reach_b37", 32'(bus.rom_cs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_pal_we", 32'(bus.pal_we), 32'd0);
    chk("abort_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("abort_pal_din", 32'(bus.pal_din), 32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (20) @(negedge clk);
    chk("abort_no_irq", 32'(irq_cnt), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    start_req(8'h91);
    run_to_irq(NB * 4, -1);

`ifdef JTKUNIO_PALDMA_VBLANK_EN
    // fetches only during vertical blank; an in-flight byte still completes
    rom_lat = 1;
    bus.LVBL = 1'b1;
    start_req(8'h22);
    repeat (20) @(negedge clk);
    chk("vb_hold_cs", 32'(cs_cnt), 32'd0);
    bus.LVBL = 1'b0;
    k = 0;
    while (!(bus.rom_cs && bus.rom_addr[AW-1:0] == AW'(100)) && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("vb_reach_b100", 32'(bus.rom_cs), 32'd1);
    bus.LVBL = 1'b1;
    k = 0;
    while (we_cnt < 101 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("vb_b100_written", 32'(we_cnt), 32'd101);
    c = cs_cnt;
    repeat (30) @(negedge clk);
    chk("vb_no_fetch", 32'(cs_cnt), 32'(c));
    chk("vb_busy", 32'(bus.busy), 32'd1);
    bus.LVBL = 1'b0;
    run_to_irq(-1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkunio_paldma.md
JTKUNIO_PALDMA -- requirements
Module: jtkunio_paldma

Interface
REQ-001 SHALL have parameter AW, default 9, palette address width; one transfer is 2^AW bytes.
REQ-002 SHALL have port rst  input  1  synchronous active-high reset.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port LVBL  input  1  vertical blank, active low.
REQ-005 SHALL have port dma_cs  input  1  CPU write strobe requesting a transfer, qualified by clk.
REQ-006 SHALL have port cpu_dout  input  8  source page number, sampled with dma_cs.
REQ-007 SHALL have port rom_addr  output  8+AW  byte address {page, idx}.
REQ-008 SHALL have port rom_cs  output  1  ROM read request.
REQ-009 SHALL have port rom_ok  input  1  ROM data valid.
REQ-010 SHALL have port rom_data  input  8  ROM byte.
REQ-011 SHALL have port pal_we  output  1  palette RAM write enable.
REQ-012 SHALL have port pal_addr  output  AW  palette RAM write address.
REQ-013 SHALL have port pal_din  output  8  palette RAM write data.
REQ-014 SHALL have port busy  output  1  high from accepted request until DONE.
REQ-015 SHALL have port dma_irq  output  1  one-cycle pulse at transfer end.

Function
REQ-016 SHALL implement states IDLE, WAIT, FETCH, WRITE, DONE.
REQ-017 IDLE: dma_cs high SHALL latch page=cpu_dout, clear idx, set busy, go to WAIT next cycle.
REQ-018 dma_cs while busy SHALL be ignored; page and idx unchanged.
REQ-019 WAIT: SHALL go to FETCH when the start condition holds (see REQ-028/029).
REQ-020 FETCH: rom_cs=1, rom_addr={page,idx}; rom_ok SHALL be ignored in the first FETCH cycle (stale-ok guard).
REQ-021 FETCH: rom_ok=1 from the second cycle on SHALL latch rom_data into pal_din, drop rom_cs and go to WRITE in the same edge.
REQ-022 WRITE: pal_we=1 for exactly one cycle with pal_addr=idx, pal_din=latched byte.
REQ-023 After WRITE: idx==2^AW-1 -> DONE; otherwise idx+1 (AW-bit, no wrap into page) and go to WAIT.
REQ-024 DONE: dma_irq=1 for one cycle, busy=0 in the same cycle, next state IDLE.
REQ-025 Minimum per-byte cost SHALL be 4 cycles (WAIT, FETCH x2, WRITE); rom_ok latency adds cycles 1:1.
REQ-026 pal_we SHALL never be asserted outside WRITE; rom_cs never outside FETCH.

Reset
REQ-027 rst SHALL force IDLE, idx=0, page=0, pal_din=0, and all outputs low/zero on the next edge, including mid-transfer; the interrupted transfer SHALL NOT resume.

Configuration
REQ-028 With macro JTKUNIO_PALDMA_VBLANK_EN defined: WAIT SHALL advance only while LVBL=0; LVBL rising during FETCH/WRITE SHALL let the current byte complete, then hold in WAIT until LVBL=0 again.
REQ-029 Without JTKUNIO_PALDMA_VBLANK_EN: WAIT SHALL advance unconditionally after one cycle; LVBL ignored.

Verification
REQ-030 AW=9, macro off, dma_cs with cpu_dout=0x05, rom_ok 2 cycles after rom_cs -> 512 pal_we pulses, addresses 0..511, rom_addr 0x0A00..0x0BFF, single dma_irq, busy low same cycle.
REQ-031 rom_ok held high constantly -> first FETCH cycle ignored; each byte takes exactly 4 cycles; total 2048 cycles from WAIT entry to DONE.
REQ-032 Macro on, LVBL=1 at request -> no rom_cs until LVBL=0; LVBL toggled high at byte 100 -> byte 100 written, byte 101 fetched only after next LVBL=0.
REQ-033 Second dma_cs with cpu_dout=0x07 mid-transfer -> ignored; all rom_addr keep page 0x05.
REQ-034 rst asserted at byte 37 during FETCH -> next cycle rom_cs=0, busy=0, pal_we=0; no dma_irq; new request restarts at idx 0.
